// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory and ALU, with optional memory-ready stalls and extended opcodes.
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b0,
  parameter bit EXT_OPS     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       immext,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic       w_ready;

  // Without the handshake every access completes in its first cycle.
  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state   = r_state;

  // State and captured-opcode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= op;
      end else begin
        r_op <= r_op;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next    = S_FETCH;
    mem_req   = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    immext    = 1'b0;
    aluop     = ALU_ADD;
    illegal   = 1'b0;
    if (reset) begin
      // Only the FETCH selects survive reset; every enable and request stays low.
      alusrcb = 2'b01;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          if (w_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            w_next  = S_DECODE;
          end else begin
            w_next  = S_FETCH;
          end
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_EXECUTE;
            OP_BEQ:       w_next = S_BRANCH;
            OP_ADDI:      w_next = S_IMMEX;
            OP_J:         w_next = S_JUMP;
            OP_BNE: begin
              if (EXT_OPS) begin
                w_next  = S_BRANCH;
              end else begin
                w_next  = S_FETCH;
                illegal = 1'b1;
              end
            end
            OP_SLTI, OP_ANDI, OP_ORI: begin
              if (EXT_OPS) begin
                w_next  = S_IMMEX;
              end else begin
                w_next  = S_FETCH;
                illegal = 1'b1;
              end
            end
            default: begin
              w_next  = S_FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          if (r_op == OP_LW) begin
            w_next = S_MEMRD;
          end else if (r_op == OP_SW) begin
            w_next = S_MEMWR;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          w_next  = w_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          w_next   = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
          w_next   = w_ready ? S_FETCH : S_MEMWR;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          aluop   = ALU_FUNCT;
          w_next  = S_ALUWB;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          alusrca   = 1'b1;
          aluop     = ALU_SUB;
          pcsrc     = 2'b01;
          branch    = (r_op == OP_BEQ);
          branch_ne = EXT_OPS && (r_op == OP_BNE);
          w_next    = S_FETCH;
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          w_next  = S_IMMWB;
          case (r_op)
            OP_SLTI: aluop = ALU_SLT;
            OP_ANDI: begin
              aluop  = ALU_AND;
              immext = 1'b1;
            end
            OP_ORI: begin
              aluop  = ALU_OR;
              immext = 1'b1;
            end
            default: aluop = ALU_ADD;
          endcase
        end
        S_IMMWB: begin
          regwrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          w_next  = S_FETCH;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven, scoreboarded bench for multicycle_ctrl: one instance without
// memory wait / extended ops, one with both enabled.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct {
    logic        sel;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [23:0] exp;
    logic [23:0] msk;
    string       nm;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [23:0] exp;
    logic [23:0] msk;
    string       nm;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rdy0, rdy1;
  logic [5:0] op0, op1;
  logic       mr0, io0, irw0, pcw0, rw0, mw0, br0, bn0, asa0, rd0, mtr0, ime0, ill0;
  logic       mr1, io1, irw1, pcw1, rw1, mw1, br1, bn1, asa1, rd1, mtr1, ime1, ill1;
  logic [1:0] asb0, pcs0, asb1, pcs1;
  logic [2:0] aop0, aop1;
  logic [3:0] st0, st1;
  logic [23:0] o0, o1;

  assign o0 = {mr0, io0, irw0, pcw0, rw0, mw0, br0, bn0, asa0, asb0, pcs0, rd0, mtr0, ime0, aop0, ill0, st0};
  assign o1 = {mr1, io1, irw1, pcw1, rw1, mw1, br1, bn1, asa1, asb1, pcs1, rd1, mtr1, ime1, aop1, ill1, st1};

  multicycle_ctrl #(.MEM_WAIT_EN(1'b0), .EXT_OPS(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .op(op0), .mem_ready(rdy0),
    .mem_req(mr0), .iord(io0), .irwrite(irw0), .pcwrite(pcw0), .regwrite(rw0),
    .memwrite(mw0), .branch(br0), .branch_ne(bn0), .alusrca(asa0), .alusrcb(asb0),
    .pcsrc(pcs0), .regdst(rd0), .memtoreg(mtr0), .immext(ime0), .aluop(aop0),
    .illegal(ill0), .state(st0)
  );

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .EXT_OPS(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .op(op1), .mem_ready(rdy1),
    .mem_req(mr1), .iord(io1), .irwrite(irw1), .pcwrite(pcw1), .regwrite(rw1),
    .memwrite(mw1), .branch(br1), .branch_ne(bn1), .alusrca(asa1), .alusrcb(asb1),
    .pcsrc(pcs1), .regdst(rd1), .memtoreg(mtr1), .immext(ime1), .aluop(aop1),
    .illegal(ill1), .state(st1)
  );

  // flags = {mem_req, iord, irwrite, pcwrite, regwrite, memwrite, branch, branch_ne, alusrca}
  function automatic logic [23:0] mk(input logic [8:0] flags, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] rmi,
                                     input logic [2:0] aop, input logic ill,
                                     input logic [3:0] st);
    return {flags, asb, pcs, rmi, aop, ill, st};
  endfunction

  vec_t vq[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic s, input logic r, input logic [5:0] o, input logic rd,
                     input logic [23:0] e, input logic [23:0] m, input string n);
    vec_t v;
    v.sel = s; v.rst = r; v.op = o; v.rdy = rd; v.exp = e; v.msk = m; v.nm = n;
    vq.push_back(v);
  endtask

  logic [23:0] RST, FRDY, FWT, DEC, DECI, MADR, MRD, MWB, MWR, EXE, AWB;
  logic [23:0] BQ, BN, IADD, IOR, IWB, JP, ALL, WEN;

  initial begin
    int waits, cyc, npulse;
    logic done;
    sb_t e;
    logic [23:0] got;

    RST  = mk(9'b000000000, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0, 4'd0);
    FRDY = mk(9'b101100000, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0, 4'd0);
    FWT  = mk(9'b100000000, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0, 4'd0);
    DEC  = mk(9'b000000000, 2'b11, 2'b00, 3'b000, 3'b000, 1'b0, 4'd1);
    DECI = mk(9'b000000000, 2'b11, 2'b00, 3'b000, 3'b000, 1'b1, 4'd1);
    MADR = mk(9'b000000001, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 4'd2);
    MRD  = mk(9'b110000000, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 4'd3);
    MWB  = mk(9'b000010000, 2'b00, 2'b00, 3'b010, 3'b000, 1'b0, 4'd4);
    MWR  = mk(9'b110001000, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 4'd5);
    EXE  = mk(9'b000000001, 2'b00, 2'b00, 3'b000, 3'b010, 1'b0, 4'd6);
    AWB  = mk(9'b000010000, 2'b00, 2'b00, 3'b100, 3'b000, 1'b0, 4'd7);
    BQ   = mk(9'b000000101, 2'b00, 2'b01, 3'b000, 3'b001, 1'b0, 4'd8);
    BN   = mk(9'b000000011, 2'b00, 2'b01, 3'b000, 3'b001, 1'b0, 4'd8);
    IADD = mk(9'b000000001, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 4'd9);
    IOR  = mk(9'b000000001, 2'b10, 2'b00, 3'b001, 3'b100, 1'b0, 4'd9);
    IWB  = mk(9'b000010000, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 4'd10);
    JP   = mk(9'b000100000, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 4'd11);
    ALL  = 24'hFFFFFF;
    WEN  = mk(9'b001111000, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 4'd0);

    // dut0: no wait, base opcodes; mem_ready held low to show it is ignored
    add(1'b0, 1'b1, LW,   1'b0, RST,  ALL, "d0_reset");
    add(1'b0, 1'b0, LW,   1'b0, FRDY, ALL, "d0_lw_fetch");
    add(1'b0, 1'b0, LW,   1'b0, DEC,  ALL, "d0_lw_dec");
    add(1'b0, 1'b0, LW,   1'b0, MADR, ALL, "d0_lw_madr");
    add(1'b0, 1'b0, LW,   1'b0, MRD,  ALL, "d0_lw_mrd");
    add(1'b0, 1'b0, LW,   1'b0, MWB,  ALL, "d0_lw_mwb");
    add(1'b0, 1'b0, SW,   1'b0, FRDY, ALL, "d0_sw_fetch");
    add(1'b0, 1'b0, SW,   1'b0, DEC,  ALL, "d0_sw_dec");
    add(1'b0, 1'b0, SW,   1'b0, MADR, ALL, "d0_sw_madr");
    add(1'b0, 1'b0, SW,   1'b0, MWR,  ALL, "d0_sw_mwr");
    add(1'b0, 1'b0, RTY,  1'b0, FRDY, ALL, "d0_r_fetch");
    add(1'b0, 1'b0, RTY,  1'b0, DEC,  ALL, "d0_r_dec");
    add(1'b0, 1'b0, RTY,  1'b0, EXE,  ALL, "d0_r_exe");
    add(1'b0, 1'b0, RTY,  1'b0, AWB,  ALL, "d0_r_awb");
    add(1'b0, 1'b0, BEQ,  1'b0, FRDY, ALL, "d0_beq_fetch");
    add(1'b0, 1'b0, BEQ,  1'b0, DEC,  ALL, "d0_beq_dec");
    add(1'b0, 1'b0, BEQ,  1'b0, BQ,   ALL, "d0_beq_br");
    add(1'b0, 1'b0, ADDI, 1'b0, FRDY, ALL, "d0_addi_fetch");
    add(1'b0, 1'b0, ADDI, 1'b0, DEC,  ALL, "d0_addi_dec");
    add(1'b0, 1'b0, ADDI, 1'b0, IADD, ALL, "d0_addi_ex");
    add(1'b0, 1'b0, ADDI, 1'b0, IWB,  ALL, "d0_addi_wb");
    add(1'b0, 1'b0, JMP,  1'b0, FRDY, ALL, "d0_j_fetch");
    add(1'b0, 1'b0, JMP,  1'b0, DEC,  ALL, "d0_j_dec");
    add(1'b0, 1'b0, JMP,  1'b0, JP,   ALL, "d0_j_jump");
    add(1'b0, 1'b0, ORI,  1'b0, FRDY, ALL, "d0_ori_fetch");
    add(1'b0, 1'b0, ORI,  1'b0, DECI, ALL, "d0_ori_illegal");
    add(1'b0, 1'b0, BNE,  1'b0, FRDY, ALL, "d0_bne_fetch");
    add(1'b0, 1'b0, BNE,  1'b0, DECI, ALL, "d0_bne_illegal");
    add(1'b0, 1'b0, RTY,  1'b0, FRDY, ALL, "d0_after_illegal");

    // dut1: memory wait and extended opcodes
    add(1'b1, 1'b1, LW,   1'b0, RST,  ALL, "d1_reset");
    add(1'b1, 1'b0, LW,   1'b0, FWT,  ALL, "d1_lw_fwait1");
    add(1'b1, 1'b0, LW,   1'b0, FWT,  ALL, "d1_lw_fwait2");
    add(1'b1, 1'b0, LW,   1'b0, FWT,  ALL, "d1_lw_fwait3");
    add(1'b1, 1'b0, LW,   1'b1, FRDY, ALL, "d1_lw_fetch");
    add(1'b1, 1'b0, LW,   1'b0, DEC,  ALL, "d1_lw_dec");
    add(1'b1, 1'b0, LW,   1'b0, MADR, ALL, "d1_lw_madr");
    add(1'b1, 1'b0, LW,   1'b0, MRD,  ALL, "d1_lw_mrwait1");
    add(1'b1, 1'b0, LW,   1'b0, MRD,  ALL, "d1_lw_mrwait2");
    add(1'b1, 1'b0, LW,   1'b1, MRD,  ALL, "d1_lw_mrd");
    add(1'b1, 1'b0, LW,   1'b0, MWB,  ALL, "d1_lw_mwb");
    add(1'b1, 1'b0, ORI,  1'b1, FRDY, ALL, "d1_ori_fetch");
    add(1'b1, 1'b0, ORI,  1'b0, DEC,  ALL, "d1_ori_dec");
    add(1'b1, 1'b0, ORI,  1'b0, IOR,  ALL, "d1_ori_ex");
    add(1'b1, 1'b0, ORI,  1'b0, IWB,  ALL, "d1_ori_wb");
    add(1'b1, 1'b0, BNE,  1'b1, FRDY, ALL, "d1_bne_fetch");
    add(1'b1, 1'b0, BNE,  1'b0, DEC,  ALL, "d1_bne_dec");
    add(1'b1, 1'b0, BNE,  1'b0, BN,   ALL, "d1_bne_br");
    add(1'b1, 1'b0, SW,   1'b1, FRDY, ALL, "d1_sw_fetch");
    add(1'b1, 1'b0, SW,   1'b0, DEC,  ALL, "d1_sw_dec");
    add(1'b1, 1'b0, SW,   1'b0, MADR, ALL, "d1_sw_madr");
    add(1'b1, 1'b0, SW,   1'b0, MWR,  ALL, "d1_sw_mwwait");
    add(1'b1, 1'b0, SW,   1'b1, MWR,  ALL, "d1_sw_mwr");
    add(1'b1, 1'b0, SW,   1'b1, FRDY, ALL, "d1_swr_fetch");
    add(1'b1, 1'b0, SW,   1'b0, DEC,  ALL, "d1_swr_dec");
    add(1'b1, 1'b0, SW,   1'b0, MADR, ALL, "d1_swr_madr");
    add(1'b1, 1'b0, SW,   1'b0, MWR,  ALL, "d1_swr_mwr");
    add(1'b1, 1'b1, SW,   1'b0, 24'd0, WEN, "d1_swr_reset_wen");
    add(1'b1, 1'b0, SW,   1'b0, FWT,  ALL, "d1_swr_after_reset");

    rst0 = 1'b1; rst1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; op0 = LW; op1 = LW;
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (vq[i].sel) begin
        rst1 = vq[i].rst; op1 = vq[i].op; rdy1 = vq[i].rdy;
      end else begin
        rst0 = vq[i].rst; op0 = vq[i].op; rdy0 = vq[i].rdy;
      end
      e.sel = vq[i].sel; e.exp = vq[i].exp; e.msk = vq[i].msk; e.nm = vq[i].nm;
      sbq.push_back(e);
      #1;
      e = sbq.pop_front();
      got = e.sel ? o1 : o0;
      n_cmp++;
      if ((got & e.msk) !== (e.exp & e.msk)) begin
        n_err++;
        $display("FAIL %s: got %h expected %h (mask %h)", e.nm, got, e.exp, e.msk);
      end
    end

    // lw with random ready stalls: latency is 5 plus one per stalled cycle
    @(negedge clk); rst1 = 1'b1; op1 = LW; rdy1 = 1'b1;
    @(negedge clk); rst1 = 1'b0;
    waits = 0; cyc = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0) @(negedge clk);
      rdy1 = 1'($urandom_range(0, 1));
      #1;
      if ((st1 == 4'd0 || st1 == 4'd3) && !rdy1) waits++;
      cyc++;
      if (st1 == 4'd4) done = 1'b1;
    end
    n_cmp++;
    if (!done || cyc != 5 + waits) begin
      n_err++;
      $display("FAIL lw_random_stall: got %0d cycles (done=%0b) expected %0d", cyc, done, 5 + waits);
    end

    // undecodable opcode: illegal for exactly one cycle, then back in FETCH
    @(negedge clk); rst1 = 1'b1; op1 = 6'b111111; rdy1 = 1'b1;
    @(negedge clk); rst1 = 1'b0;
    npulse = 0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (ill1) npulse++;
    end
    n_cmp++;
    if (npulse != 1) begin
      n_err++;
      $display("FAIL illegal_pulse: got %0d cycles expected 1", npulse);
    end
    n_cmp++;
    if (st1 !== 4'd0) begin
      n_err++;
      $display("FAIL illegal_return: got state %0d expected 0", st1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle main controller for the MIPS core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles on a shared memory and ALU. It optionally stalls on a memory ready handshake and optionally decodes an extended opcode set. It sits between the instruction register's opcode field and the multicycle datapath's mux selects and write enables.

## Interface
- `MEM_WAIT_EN`, default 0: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` is ignored and treated as 1.
- `EXT_OPS`, default 0: 1 = additionally decode bne (000101), slti (001010), andi (001100) and ori (001101); 0 = those opcodes are illegal.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: opcode, IR[31:26]; sampled in DECODE only.
- `mem_ready` in 1: memory completes the access this cycle.
- `mem_req` out 1: memory access requested.
- `iord` out 1: 0 = memory address from PC; 1 = memory address from ALUOut.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite` out 1 each: write enables.
- `branch` out 1: PC written if ALU zero (beq).
- `branch_ne` out 1: PC written if not zero (bne).
- `alusrca` out 1: 0 = ALU A from PC; 1 = ALU A from register A.
- `alusrcb` out 2: ALU B select. 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- `pcsrc` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `regdst` out 1: 1 = write rd; 0 = write rt.
- `memtoreg` out 1: 1 = write data from memory data register.
- `immext` out 1: 1 = zero-extend the immediate; 0 = sign-extend.
- `aluop` out 3: 000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt.
- `illegal` out 1: single-cycle pulse on an undecodable opcode.
- `state` out 4: current state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12–15 return to FETCH.
- Every output defaults to 0 in every state; each state below asserts only what it lists.
- FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=add, `pcsrc`=00.
  - `irwrite` and `pcwrite` are asserted only in the cycle `mem_ready`=1; the FSM moves to DECODE in that same cycle.
  - Otherwise it holds in FETCH.
- DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=add. Next state by `op`:
  - lw, sw → MEMADR.
  - R-type (000000) → EXECUTE.
  - beq, and bne when `EXT_OPS`=1 → BRANCH.
  - addi, and slti/andi/ori when `EXT_OPS`=1 → IMMEX.
  - j → JUMP.
  - Any other opcode → FETCH with `illegal`=1 for that cycle. The PC has already advanced by 4.
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=add. Next state is MEMRD for lw, MEMWR for sw; the opcode is held in a register captured in DECODE.
- MEMRD: `mem_req`=1, `iord`=1. Moves to MEMWB when `mem_ready`=1.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0. Next state FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1 for the whole state. Moves to FETCH when `mem_ready`=1.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `aluop`=funct. Next state ALUWB.
- ALUWB: `regwrite`=1, `regdst`=1. Next state FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=sub, `pcsrc`=01. Asserts `branch` (beq) or `branch_ne` (bne). Next state FETCH.
- IMMEX: `alusrca`=1, `alusrcb`=10.
  - `aluop` by opcode: addi → add, slti → slt, andi → and, ori → or.
  - `immext`=1 for andi and ori.
  - Next state IMMWB.
- IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0. Next state FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1. Next state FETCH.

## Timing
- Reset: when `reset`=1 at a rising edge, the state becomes FETCH and the opcode register clears to 0.
  - This takes effect from any state, including mid-access; an abandoned memory request is simply dropped.
  - While in reset, all outputs except the FETCH selects read 0.
- All outputs are decoded combinationally from the registered state, the registered opcode and `mem_ready` (Mealy only for the write enables that are gated by `mem_ready`).
- Latency with `MEM_WAIT_EN`=0, in cycles including FETCH:
  - beq, bne, j: 3.
  - R-type, addi/ext immediate ops, sw: 4.
  - lw: 5.
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. `mem_ready` outside those states is ignored.
- `illegal` is high for exactly one cycle, in DECODE.

## Test plan
- `reset` held for 2 cycles, then released:
  - During reset, `state`=0 and `pcwrite`=`regwrite`=`memwrite`=0.
  - First cycle after release, FETCH with `irwrite`=`pcwrite`=1.
- `MEM_WAIT_EN`=0, `op` sequence lw, sw, R-type, beq, addi, j → state traces 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-8, 0-1-9-10, 0-1-11; 23 cycles total.
- `MEM_WAIT_EN`=1, lw with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEMRD:
  - 10 cycles total.
  - `irwrite` asserted only in the ready cycle.
- `EXT_OPS`=0, `op`=001101 → `illegal`=1 in DECODE, back to FETCH. `EXT_OPS`=1, same `op` → IMMEX with `aluop`=100 and `immext`=1.
- bne with `EXT_OPS`=1 → BRANCH with `branch_ne`=1 and `branch`=0.
- `reset` asserted during MEMWR with `mem_ready`=0 → FETCH on the next edge, `memwrite`=0.
